post_pack_writer: RTL and testbench
===================================

// Module: post_pack_writer
// PURPOSE
//  Downstream of the BN/act/quant post-process stage. Collects the four per-batch-pair 8-bit output
//  byte pairs (b01,b23,b45,b67), packs them into a 64-bit output word and queues it in a FIFO.
//  Presents each word with a feature-map write address on a valid/ready port to write-back.
//  Pulses done after the last word of the layer is accepted.
// PARAMETERS
//  DATA_WIDTH_O  8    bits per output byte from post-process (word = 8*DATA_WIDTH_O)
//  FIFO_DEPTH    16   output FIFO entries, power of 2, >=4
//  ADDR_WIDTH    20   write address width
//  AFULL_MARGIN  4    almost_full asserts when free entries <= AFULL_MARGIN
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous active-high reset
//  start         in   1      1-cycle pulse: latch config, clear counters
//  width_out     in   8      columns-1 of output map
//  height_out    in   10     rows-1 of output map
//  base_addr     in   ADDR_WIDTH  first write address
//  en_in         in   4      per-group valid from post-process: [0]=b01 [1]=b23 [2]=b45 [3]=b67
//  din0_b01..din0_b67, din1_b01..din1_b67  in  DATA_WIDTH_O  bn0/bn1 bytes per group
//  almost_full   out  1      backpressure hint to upstream scheduler
//  wr_valid      out  1      word available
//  wr_ready      in   1      sink accepts when wr_valid&wr_ready
//  wr_addr       out  ADDR_WIDTH  address of wr_data
//  wr_data       out  8*DATA_WIDTH_O  {b67_1,b67_0,b45_1,b45_0,b23_1,b23_0,b01_1,b01_0}
//  busy          out  1      high from start until done
//  done          out  1      1-cycle pulse after last word accepted
//  err_overflow  out  1      sticky: group double-write or FIFO-full drop
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; staging valid bits 0; FSM IDLE; err_overflow cleared.
//  FSM IDLE -> RUN on start (config latched that cycle); RUN -> DRAIN when the last word
//   (total=(width_out+1)*(height_out+1)) is pushed; DRAIN -> IDLE when FIFO empty, done=1 that
//   cycle. start outside IDLE is ignored.
//  Staging: per group k, en_in[k] loads its 2 bytes and sets stg_v[k]. When all stg_v are set
//   (including bits set this cycle), the word is pushed next cycle and stg_v is cleared;
//   en_in in the same push cycle starts the next word (no bubble).
//  en_in[k] while stg_v[k]=1 and not clearing: new bytes dropped, err_overflow set.
//  en_in in IDLE/DRAIN: ignored, err_overflow unchanged.
//  FIFO: first-word latency from the final group enable to wr_valid = 2 cycles. Simultaneous push
//   and pop when full is allowed (count unchanged). A push when full and no pop drops the word,
//   sets err_overflow, and the address counter still advances.
//  Address: wr_addr = base_addr + word index (0..total-1), stored alongside data in the FIFO;
//   wraps modulo 2^ADDR_WIDTH.
//  wr_valid/wr_data/wr_addr are held stable while wr_valid & !wr_ready.
//  almost_full is combinational on the FIFO count.
//  Reset mid-layer: immediate return to IDLE, FIFO flushed, no done pulse.
// TESTING
//  1) width_out=1,height_out=0,base=0x100; all 4 en same cycle, bytes 0x01..0x08, ready=1 ->
//     2 words, addrs 0x100,0x101, wr_data=0x0807060504030201, done 2 cycles after last en.
//  2) en[0],en[1],en[2],en[3] on successive cycles -> one word pushed 2 cycles after en[3];
//     no error.
//  3) en[0] twice before the other groups arrive -> err_overflow=1; first bytes kept.
//  4) wr_ready=0 with FIFO_DEPTH=16: push 17 words -> almost_full at 12 used; 17th dropped;
//     err_overflow=1; data held stable.
//  5) ready toggling 1/0 over a 4x3 map -> 12 words in order, addrs base..base+11, one done pulse.
//  6) rst asserted mid-layer with 5 words queued -> wr_valid=0 next cycle, busy=0, no done.

Source files
------------

// File: rtl/post_pack_writer.sv
// rtl/post_pack_writer.sv - packs post-process byte pairs into output words and queues them for write-back
//
// Collects the four per-group byte pairs coming out of the BN/act/quant stage,
// packs them into one 8*DATA_WIDTH_O-bit word, tags it with its feature-map
// address and queues it in a small FIFO that drains over a valid/ready port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               1-cycle pulse in IDLE: latch geometry/base, clear counters
//   width_out           output map columns-1
//   height_out          output map rows-1
//   base_addr           address of word 0
//   en_in[3:0]          per-group load strobes: [0]=b01 [1]=b23 [2]=b45 [3]=b67
//   din0_*/din1_*       bn0/bn1 bytes for each group
//   almost_full         free FIFO entries <= AFULL_MARGIN
//   wr_valid/wr_ready   write-back handshake
//   wr_addr/wr_data     head-of-FIFO address and word
//   busy                layer in progress
//   done                1-cycle pulse once the last word has left the FIFO
//   err_overflow        sticky: group double-write or word dropped on full FIFO

module post_pack_writer #(
    parameter int DATA_WIDTH_O = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_WIDTH   = 20,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                width_out,
    input  logic [9:0]                height_out,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [3:0]                en_in,
    input  logic [DATA_WIDTH_O-1:0]   din0_b01,
    input  logic [DATA_WIDTH_O-1:0]   din0_b23,
    input  logic [DATA_WIDTH_O-1:0]   din0_b45,
    input  logic [DATA_WIDTH_O-1:0]   din0_b67,
    input  logic [DATA_WIDTH_O-1:0]   din1_b01,
    input  logic [DATA_WIDTH_O-1:0]   din1_b23,
    input  logic [DATA_WIDTH_O-1:0]   din1_b45,
    input  logic [DATA_WIDTH_O-1:0]   din1_b67,
    output logic                      almost_full,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [8*DATA_WIDTH_O-1:0] wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err_overflow
);

    localparam int WORD_W = 8 * DATA_WIDTH_O;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // (255+1)*(1023+1) words needs 19 bits of index
    localparam int IDX_W  = 19;
    localparam int ENT_W  = ADDR_WIDTH + WORD_W;
    localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH_O-1:0] din0_a [4];
    logic [DATA_WIDTH_O-1:0] din1_a [4];

    assign din0_a[0] = din0_b01;
    assign din0_a[1] = din0_b23;
    assign din0_a[2] = din0_b45;
    assign din0_a[3] = din0_b67;
    assign din1_a[0] = din1_b01;
    assign din1_a[1] = din1_b23;
    assign din1_a[2] = din1_b45;
    assign din1_a[3] = din1_b67;

    logic [3:0]              stg_v_q, stg_v_d;
    logic [3:0]              stg_ld;
    logic [3:0]              stg_dbl;
    logic [DATA_WIDTH_O-1:0] stg0_q [4];
    logic [DATA_WIDTH_O-1:0] stg1_q [4];

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        tot_m1_q, tot_m1_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;

    logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [PTR_W-1:0]        rptr_q, rptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic                    start_ok;
    logic                    in_run;
    logic                    push;
    logic                    last_word;
    logic                    load_ok;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    do_pop;
    logic                    do_write;
    logic                    drop;
    logic [WORD_W-1:0]       word_data;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [ENT_W-1:0]        head;

    assign word_data = {stg1_q[3], stg0_q[3], stg1_q[2], stg0_q[2],
                        stg1_q[1], stg0_q[1], stg1_q[0], stg0_q[0]};
    assign word_addr = base_q + ADDR_WIDTH'(idx_q);

    // Staging, counters and FIFO bookkeeping
    always_comb begin
        start_ok   = (state_q == S_IDLE) && start;
        in_run     = (state_q == S_RUN);
        // A complete staging set is pushed in the cycle after it fills; that same
        // cycle may already load the next word's groups.
        push       = in_run && (stg_v_q == 4'hF);
        last_word  = (idx_q == tot_m1_q);
        // Nothing past the final word of the layer may be staged.
        load_ok    = in_run && !(push && last_word);
        fifo_full  = (cnt_q == FULL_LEVEL);
        fifo_empty = (cnt_q == '0);
        do_pop     = !fifo_empty && wr_ready;
        // On a full FIFO the word still fits if the head leaves this cycle.
        do_write   = push && (!fifo_full || do_pop);
        drop       = push && fifo_full && !do_pop;

        stg_ld  = '0;
        stg_dbl = '0;
        for (int k = 0; k < 4; k++) begin
            stg_ld[k]  = load_ok && en_in[k] && (push || !stg_v_q[k]);
            stg_dbl[k] = load_ok && en_in[k] && !push && stg_v_q[k];
        end

        stg_v_d = (push ? 4'h0 : stg_v_q) | stg_ld;
        if (start_ok) begin
            stg_v_d = 4'h0;
        end

        base_d   = start_ok ? base_addr : base_q;
        tot_m1_d = tot_m1_q;
        if (start_ok) begin
            tot_m1_d = (IDX_W'(width_out) + IDX_W'(1)) * (IDX_W'(height_out) + IDX_W'(1))
                       - IDX_W'(1);
        end

        // The index advances even when the word is dropped so later addresses stay right.
        idx_d = idx_q;
        if (start_ok) begin
            idx_d = '0;
        end else if (push) begin
            idx_d = idx_q + IDX_W'(1);
        end

        wptr_d = do_write ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = do_pop   ? rptr_q + PTR_W'(1) : rptr_q;

        cnt_d = cnt_q;
        case ({do_write, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | (|stg_dbl) | drop;
    end

    // FSM next state and done
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (push && last_word) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            stg_v_q  <= '0;
            idx_q    <= '0;
            tot_m1_q <= '0;
            base_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                stg0_q[k] <= '0;
                stg1_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            stg_v_q  <= stg_v_d;
            idx_q    <= idx_d;
            tot_m1_q <= tot_m1_d;
            base_q   <= base_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            for (int k = 0; k < 4; k++) begin
                if (stg_ld[k]) begin
                    stg0_q[k] <= din0_a[k];
                    stg1_q[k] <= din1_a[k];
                end
            end
        end
    end

    // Storage array carries no reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wptr_q] <= {word_addr, word_data};
        end
    end

    assign head         = mem_q[rptr_q];
    assign wr_valid     = !fifo_empty;
    assign wr_data      = wr_valid ? head[WORD_W-1:0] : '0;
    assign wr_addr      = wr_valid ? head[ENT_W-1:WORD_W] : '0;
    assign almost_full  = (cnt_q >= AF_LEVEL);
    assign busy         = (state_q != S_IDLE);
    assign err_overflow = err_q;

endmodule

// File: tb/tb_post_pack_writer.sv
// tb/tb_post_pack_writer.sv - scoreboard bench for post_pack_writer

module tb_post_pack_writer;

    localparam int DW  = 8;
    localparam int FD  = 16;
    localparam int AW  = 20;
    localparam int AFM = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     width_out = '0;
    logic [9:0]     height_out = '0;
    logic [AW-1:0]  base_addr = '0;
    logic [3:0]     en_in = '0;
    logic [DW-1:0]  d0 [4];
    logic [DW-1:0]  d1 [4];
    logic           almost_full;
    logic           wr_valid;
    logic           wr_ready = 1'b0;
    logic [AW-1:0]  wr_addr;
    logic [8*DW-1:0] wr_data;
    logic           busy;
    logic           done;
    logic           err_overflow;

    always #5 clk = ~clk;

    post_pack_writer #(
        .DATA_WIDTH_O (DW),
        .FIFO_DEPTH   (FD),
        .ADDR_WIDTH   (AW),
        .AFULL_MARGIN (AFM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .width_out    (width_out),
        .height_out   (height_out),
        .base_addr    (base_addr),
        .en_in        (en_in),
        .din0_b01     (d0[0]),
        .din0_b23     (d0[1]),
        .din0_b45     (d0[2]),
        .din0_b67     (d0[3]),
        .din1_b01     (d1[0]),
        .din1_b23     (d1[1]),
        .din1_b45     (d1[2]),
        .din1_b67     (d1[3]),
        .almost_full  (almost_full),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [63:0]   d;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   acc_cyc = -1;
    bit   tog_run = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Every presented word is checked against the scoreboard head, which also
    // proves the word stays stable while the sink stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (wr_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'd1, 64'd0);
                end else begin
                    chk("wr_addr", 64'(wr_addr), 64'(sb[0].a));
                    chk("wr_data", wr_data, sb[0].d);
                    if (wr_ready) begin
                        void'(sb.pop_front());
                        acc_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_in = '0;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] w, input logic [9:0] h, input logic [AW-1:0] b);
        width_out = w;
        height_out = h;
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [63:0] wbytes(input int i);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(i * 16 + j + 1);
        return r;
    endfunction

    task automatic send(input logic [3:0] mask, input logic [63:0] r);
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                d0[k] = r[16*k +: 8];
                d1[k] = r[16*k+8 +: 8];
            end
        end
        en_in = mask;
        tick();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t;
        int c0;
        t = 0;
        c0 = done_cnt;
        while (done_cnt == c0 && t < budget) begin
            tick();
            t++;
        end
        chk(tag, 64'(done_cnt != c0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        logic [63:0] r;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [AW-1:0] a;

        for (int k = 0; k < 4; k++) begin
            d0[k] = '0;
            d1[k] = '0;
        end

        // Test 1: 2x1 map, all groups together, free-running sink
        do_reset();
        chk("rst_valid", 64'(wr_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_overflow), 64'd0);
        chk("rst_afull", 64'(almost_full), 64'd0);
        chk("rst_data", wr_data, 64'd0);
        wr_ready = 1'b1;
        do_start(8'd1, 10'd0, 20'h00100);
        chk("t1_busy", 64'(busy), 64'd1);
        sb.push_back('{a: 20'h00100, d: 64'h0807060504030201});
        sb.push_back('{a: 20'h00101, d: wbytes(1)});
        send(4'hF, wbytes(0));
        send(4'hF, wbytes(1));
        en_in = '0;
        c0 = done_cnt;
        wait_done("t1_done_seen", 40);
        chk("t1_done_after_accept", 64'(done_cyc - acc_cyc), 64'd1);
        repeat (4) tick();
        chk("t1_done_once", 64'(done_cnt - c0), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        chk("t1_err", 64'(err_overflow), 64'd0);

        // Test 2: groups on successive cycles, 2-cycle latency from final group
        do_reset();
        wr_ready = 1'b1;
        do_start(8'd0, 10'd0, 20'h00200);
        r = wbytes(2);
        sb.push_back('{a: 20'h00200, d: r});
        send(4'h1, r);
        send(4'h2, r);
        send(4'h4, r);
        d0[3] = r[55:48];
        d1[3] = r[63:56];
        en_in = 4'h8;
        @(negedge clk);
        chk("t2_valid_c0", 64'(wr_valid), 64'd0);
        tick();
        en_in = '0;
        @(negedge clk);
        chk("t2_valid_c1", 64'(wr_valid), 64'd0);
        @(negedge clk);
        chk("t2_valid_c2", 64'(wr_valid), 64'd1);
        tick();
        wait_done("t2_done_seen", 40);
        chk("t2_err", 64'(err_overflow), 64'd0);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Test 3: double write on group 0 keeps first bytes and flags error
        do_reset();
        wr_ready = 1'b1;
        do_start(8'd0, 10'd0, 20'h00300);
        ra = wbytes(3);
        rb = wbytes(4);
        sb.push_back('{a: 20'h00300, d: ra});
        send(4'h1, ra);
        chk("t3_err_before", 64'(err_overflow), 64'd0);
        send(4'h1, rb);
        chk("t3_err_after", 64'(err_overflow), 64'd1);
        send(4'h2, ra);
        send(4'h4, ra);
        send(4'h8, ra);
        en_in = '0;
        wait_done("t3_done_seen", 40);
        chk("t3_err_sticky", 64'(err_overflow), 64'd1);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Test 4: stalled sink, 17 words into a 16-entry FIFO
        do_reset();
        wr_ready = 1'b0;
        do_start(8'd16, 10'd0, 20'h00400);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back('{a: AW'(20'h00400 + i), d: wbytes(10 + i)});
            send(4'hF, wbytes(10 + i));
            en_in = '0;
            tick();
            @(negedge clk);
            chk($sformatf("t4_afull_%0d", i), 64'(almost_full), 64'(((i + 1) >= (FD - AFM)) ? 1 : 0));
            chk($sformatf("t4_err_%0d", i), 64'(err_overflow), 64'((i == 16) ? 1 : 0));
            tick();
        end
        repeat (3) tick();
        chk("t4_valid_stalled", 64'(wr_valid), 64'd1);
        wr_ready = 1'b1;
        wait_done("t4_done_seen", 100);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);
        chk("t4_afull_end", 64'(almost_full), 64'd0);

        // Test 5: 4x3 map, toggling ready, address wrap at the top of the space
        do_reset();
        wr_ready = 1'b1;
        do_start(8'd3, 10'd2, 20'hFFFF8);
        tog_run = 1'b1;
        fork
            while (tog_run) begin
                tick();
                wr_ready = ~wr_ready;
            end
        join_none
        c0 = done_cnt;
        for (int i = 0; i < 12; i++) begin
            r = wbytes(40 + i);
            a = 20'hFFFF8 + AW'(i);
            sb.push_back('{a: a, d: r});
            if (i % 2 == 0) begin
                send(4'hF, r);
            end else begin
                send(4'h3, r);
                send(4'hC, r);
            end
        end
        en_in = '0;
        wait_done("t5_done_seen", 200);
        tog_run = 1'b0;
        repeat (4) tick();
        wr_ready = 1'b1;
        chk("t5_done_once", 64'(done_cnt - c0), 64'd1);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        chk("t5_err", 64'(err_overflow), 64'd0);

        // Test 6: reset mid-layer with 5 words queued
        do_reset();
        wr_ready = 1'b0;
        do_start(8'd15, 10'd0, 20'h00500);
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{a: AW'(20'h00500 + i), d: wbytes(60 + i)});
            send(4'hF, wbytes(60 + i));
        end
        en_in = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("t6_valid_before", 64'(wr_valid), 64'd1);
        chk("t6_afull_before", 64'(almost_full), 64'd0);
        tick();
        c0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t6_valid_after", 64'(wr_valid), 64'd0);
        chk("t6_busy_after", 64'(busy), 64'd0);
        chk("t6_done_after", 64'(done), 64'd0);
        repeat (10) tick();
        chk("t6_no_done", 64'(done_cnt - c0), 64'd0);
        chk("t6_valid_idle", 64'(wr_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
